// File: rtl/muller_hs_sender.sv
// muller_hs_sender: clocked initiator for a four-phase (return-to-zero)
// bundled-data handshake into a Muller C-element pipeline stage.
// A word taken on the valid/ready side is placed on hs_data, held stable for
// SETUP_CYCLES edges, and then announced with hs_req. The block waits for the
// synchronised acknowledge to rise and fall before returning to idle.
// A watchdog bounds each acknowledge phase, and completed transfers are counted.
module muller_hs_sender #(
    parameter int DATA_W         = 4,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              hs_req,
    output logic [DATA_W-1:0] hs_data,
    input  logic              hs_ack,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       xfer_count
);

    // Counter widths are sized for the largest value each counter must hold.
    // The setup counter is loaded with SETUP_CYCLES-1 and counts down to zero.
    // The watchdog counts up from zero and expires at TIMEOUT_CYCLES-1.
    localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD =
        CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit HAS_SETUP = (SETUP_CYCLES > 0);
    localparam bit WD_ON     = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO,
        ERR
    } state_t;

    state_t            state;
    logic              ack_meta;
    logic              ack_s;
    logic [CNT_W-1:0]  setup_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              accept;
    logic              wd_expired;

    // hs_ack comes from the asynchronous stage. Only the second flop's output is used.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= hs_ack;
            ack_s    <= ack_meta;
        end
    end

    // A word is only taken when idle and the stage has released its acknowledge.
    assign in_ready   = (state == IDLE) && !ack_s && !wb_rst_i;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign wd_expired = WD_ON && (wd_cnt == WD_LAST);

    // Handshake sequencer. hs_req, hs_data, the watchdog and the transfer count all live here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            hs_req      <= 1'b0;
            hs_data     <= '0;
            timeout_err <= 1'b0;
            xfer_count  <= 16'h0000;
            setup_cnt   <= '0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hs_data <= in_data;
                        if (HAS_SETUP) begin
                            state     <= SETUP;
                            setup_cnt <= SETUP_LOAD;
                        end else begin
                            state  <= REQ_HI;
                            hs_req <= 1'b1;
                            wd_cnt <= '0;
                        end
                    end
                end

                SETUP: begin
                    if (setup_cnt == '0) begin
                        state  <= REQ_HI;
                        hs_req <= 1'b1;
                        wd_cnt <= '0;
                    end else begin
                        setup_cnt <= setup_cnt - CNT_W'(1);
                    end
                end

                REQ_HI: begin
                    if (ack_s) begin
                        state  <= REQ_LO;
                        hs_req <= 1'b0;
                        wd_cnt <= '0;
                    end else if (wd_expired) begin
                        state       <= ERR;
                        hs_req      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                REQ_LO: begin
                    if (!ack_s) begin
                        state      <= IDLE;
                        xfer_count <= xfer_count + 16'd1;
                    end else if (wd_expired) begin
                        state       <= ERR;
                        hs_req      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                ERR: begin
                    hs_req <= 1'b0;
                end

                default: begin
                    state  <= ERR;
                    hs_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muller_hs_sender.sv
// tb_muller_hs_sender: self-checking bench for muller_hs_sender.
// Two instances are used: dut0 holds data for two edges before the request,
// and dut1 raises the request on the accept edge. Both have an 8-cycle watchdog.
// Outputs are sampled 1 time unit after each rising edge.
module tb_muller_hs_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid    [2];
    logic [3:0]  in_data     [2];
    logic        in_ready    [2];
    logic        hs_req      [2];
    logic [3:0]  hs_data     [2];
    logic        hs_ack      [2];
    logic        busy        [2];
    logic        timeout_err [2];
    logic [15:0] xfer_count  [2];

    int passed = 0;
    int total  = 0;
    int edge_no = 0;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [3:0]  data;
        logic        ack;
        logic        rdy;
        logic        chk_rdy;
        logic        req;
        logic [3:0]  hsd;
        logic        busy;
        logic [15:0] xfer;
    } vec_t;

    vec_t       vecs [26];
    logic [3:0] words [3];

    muller_hs_sender #(.DATA_W(4), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(8)) dut0 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_data    (in_data[0]),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .hs_req     (hs_req[0]),
        .hs_data    (hs_data[0]),
        .hs_ack     (hs_ack[0]),
        .busy       (busy[0]),
        .timeout_err(timeout_err[0]),
        .xfer_count (xfer_count[0])
    );

    muller_hs_sender #(.DATA_W(4), .SETUP_CYCLES(0), .TIMEOUT_CYCLES(8)) dut1 (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_data    (in_data[1]),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .hs_req     (hs_req[1]),
        .hs_data    (hs_data[1]),
        .hs_ack     (hs_ack[1]),
        .busy       (busy[1]),
        .timeout_err(timeout_err[1]),
        .xfer_count (xfer_count[1])
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case something hangs beyond every bounded loop.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got still running, want finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    function automatic int setup_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                                input logic a, input logic rdy, input logic crdy,
                                input logic q, input logic [3:0] hd, input logic b,
                                input logic [15:0] x);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.ack = a;
        t.rdy = rdy; t.chk_rdy = crdy; t.req = q; t.hsd = hd; t.busy = b; t.xfer = x;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act === exp_v) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
    endtask

    task automatic apply_stimulus(input int k);
        rst         = vecs[k].rst;
        in_valid[0] = vecs[k].valid;
        in_data[0]  = vecs[k].data;
        hs_ack[0]   = vecs[k].ack;
    endtask

    // Random traffic against a scoreboard of accepted words and an ack responder
    // with random 0..3 cycle reaction delays.
    task automatic run_random(input int i, input int cycles);
        logic [3:0]  q [$];
        int          aq [$];
        int          accepts;
        int          dly;
        logic [15:0] x0;
        logic [3:0]  last_data;
        logic        last_req;
        logic        acc;
        logic        has;
        logic [3:0]  d;
        accepts   = 0;
        dly       = 0;
        x0        = xfer_count[i];
        last_data = hs_data[i];
        last_req  = hs_req[i];
        for (int c = 0; c < cycles + 80; c++) begin
            if (hs_req[i] && !hs_ack[i]) begin
                if (dly == 0) begin hs_ack[i] = 1'b1; dly = int'($urandom_range(3, 0)); end
                else dly--;
            end else if (!hs_req[i] && hs_ack[i]) begin
                if (dly == 0) begin hs_ack[i] = 1'b0; dly = int'($urandom_range(3, 0)); end
                else dly--;
            end
            in_valid[i] = (c < cycles) ? 1'($urandom_range(1, 0)) : 1'b0;
            in_data[i]  = 4'($urandom_range(15, 0));
            acc = in_valid[i] && in_ready[i];
            d   = in_data[i];
            step();
            if (acc) begin
                q.push_back(d);
                aq.push_back(edge_no);
                accepts++;
                check_output("rnd.data_load", 32'(hs_data[i]), 32'(d));
            end else begin
                check_output("rnd.data_hold", 32'(hs_data[i]), 32'(last_data));
            end
            if (hs_req[i] && !last_req) begin
                has = (q.size() > 0);
                check_output("rnd.req_has_word", 32'(has), 32'd1);
                if (has) begin
                    check_output("rnd.req_data", 32'(hs_data[i]), 32'(q[0]));
                    check_output("rnd.req_latency", 32'(edge_no - aq[0]), 32'(setup_of(i)));
                    void'(q.pop_front());
                    void'(aq.pop_front());
                end
            end
            check_output("rnd.busy_blocks_ready", 32'(busy[i] & in_ready[i]), 32'd0);
            last_data = hs_data[i];
            last_req  = hs_req[i];
            if (c >= cycles && !busy[i] && !hs_ack[i] && q.size() == 0) break;
        end
        in_valid[i] = 1'b0;
        check_output("rnd.queue_empty", 32'(q.size()), 32'd0);
        check_output("rnd.xfer_count", 32'(xfer_count[i]), 32'(16'(x0 + 16'(accepts))));
        check_output("rnd.no_timeout", 32'(timeout_err[i]), 32'd0);
        check_output("rnd.idle_at_end", 32'(busy[i]), 32'd0);
    endtask

    initial begin
        int n;
        int hi;
        int wi;
        int rises;
        logic prev_req;
        logic acc;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 4'h0; hs_ack[i] = 1'b0;
        end

        // Per-cycle vectors for dut0: rst, valid, data, ack | rdy, chk_rdy, req, hs_data, busy, xfer
        vecs[0]  = mk(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 16'd0);
        vecs[2]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 16'd0);
        vecs[3]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 16'd0);
        vecs[4]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 16'd0);
        vecs[5]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 16'd0);
        vecs[6]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 16'd0);
        vecs[7]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 16'd0);
        vecs[8]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b1, 16'd0);
        vecs[9]  = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[10] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[11] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[12] = mk(1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[13] = mk(1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[14] = mk(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[15] = mk(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 16'd1);
        vecs[16] = mk(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b1, 16'd1);
        vecs[17] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b1, 16'd1);
        vecs[18] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 16'd1);
        vecs[19] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 16'd1);
        vecs[20] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 16'd1);
        vecs[21] = mk(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0);
        vecs[22] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'd0);
        vecs[23] = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0);
        vecs[24] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0);
        vecs[25] = mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0);

        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3;

        // Basic transfer, stray ack, reset mid-transfer with ack still high.
        for (int k = 0; k < 26; k++) begin
            apply_stimulus(k);
            step();
            if (vecs[k].chk_rdy)
                check_output($sformatf("vec%0d.in_ready", k), 32'(in_ready[0]), 32'(vecs[k].rdy));
            check_output($sformatf("vec%0d.hs_req", k),     32'(hs_req[0]),     32'(vecs[k].req));
            check_output($sformatf("vec%0d.hs_data", k),    32'(hs_data[0]),    32'(vecs[k].hsd));
            check_output($sformatf("vec%0d.busy", k),       32'(busy[0]),       32'(vecs[k].busy));
            check_output($sformatf("vec%0d.xfer_count", k), 32'(xfer_count[0]), 32'(vecs[k].xfer));
        end
        check_output("reset.dut1_req",  32'(hs_req[1]),     32'd0);
        check_output("reset.dut1_data", 32'(hs_data[1]),    32'd0);
        check_output("reset.dut1_xfer", 32'(xfer_count[1]), 32'd0);

        // Watchdog: one word, no acknowledge ever.
        in_valid[0] = 1'b1; in_data[0] = 4'h7; hs_ack[0] = 1'b0;
        step();
        in_valid[0] = 1'b0;
        n = 0;
        while (!hs_req[0] && n < 10) begin step(); n++; end
        check_output("to.req_rise", 32'(hs_req[0]), 32'd1);
        hi = 0;
        while (hs_req[0] && hi < 20) begin hi++; step(); end
        check_output("to.req_high_cycles", 32'(hi), 32'd8);
        check_output("to.err_set", 32'(timeout_err[0]), 32'd1);
        check_output("to.busy", 32'(busy[0]), 32'd1);
        for (int c = 0; c < 4; c++) begin
            in_valid[0] = 1'b1;
            step();
            check_output("to.err_sticky", 32'(timeout_err[0]), 32'd1);
            check_output("to.req_low",    32'(hs_req[0]),      32'd0);
            check_output("to.not_ready",  32'(in_ready[0]),    32'd0);
        end
        in_valid[0] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_output("to.reset_err",   32'(timeout_err[0]), 32'd0);
        check_output("to.reset_xfer",  32'(xfer_count[0]),  32'd0);
        check_output("to.reset_busy",  32'(busy[0]),        32'd0);
        check_output("to.reset_ready", 32'(in_ready[0]),    32'd1);

        // Back-to-back stream on dut1 with an ack that follows req one sample late.
        wi = 0; rises = 0; prev_req = hs_req[1];
        for (int c = 0; c < 120; c++) begin
            hs_ack[1]   = prev_req;
            prev_req    = hs_req[1];
            in_valid[1] = (wi < 3);
            in_data[1]  = (wi < 3) ? words[wi] : 4'h0;
            acc = in_valid[1] && in_ready[1];
            step();
            if (hs_req[1] && !prev_req) rises++;
            if (acc) begin
                check_output($sformatf("b2b.data%0d", wi), 32'(hs_data[1]), 32'(words[wi]));
                check_output($sformatf("b2b.req%0d", wi),  32'(hs_req[1]),  32'd1);
                wi++;
            end
            if (wi == 3 && !busy[1] && !hs_ack[1]) break;
        end
        in_valid[1] = 1'b0;
        hs_ack[1]   = 1'b0;
        check_output("b2b.accepts",    32'(wi),            32'd3);
        check_output("b2b.req_rises",  32'(rises),         32'd3);
        check_output("b2b.xfer_count", 32'(xfer_count[1]), 32'd3);

        // Randomised traffic on both instances.
        run_random(0, 300);
        run_random(1, 300);

        // Counter wrap: preload 0xFFFF, then complete one transfer.
        step();
        force dut1.xfer_count = 16'hFFFF;
        step();
        release dut1.xfer_count;
        step();
        check_output("wrap.preload", 32'(xfer_count[1]), 32'h0000FFFF);
        in_valid[1] = 1'b1; in_data[1] = 4'h9;
        step();
        in_valid[1] = 1'b0;
        check_output("wrap.accepted", 32'(busy[1]), 32'd1);
        for (int c = 0; c < 30; c++) begin
            hs_ack[1] = hs_req[1];
            if (!busy[1] && !hs_ack[1]) break;
            step();
        end
        check_output("wrap.xfer_count", 32'(xfer_count[1]), 32'd0);
        check_output("wrap.idle",       32'(busy[1]),       32'd0);
        check_output("wrap.data_held",  32'(hs_data[1]),    32'h9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
